// File: rtl/loop_counter_if.sv
// Handshake and status bundle for loop_counter: start/count/hold/abort requests,
// ready/busy/value/tick/done/nCryOut status.
interface loop_counter_if #(
  parameter int WIDTH = 12
);
  logic             start;
  logic [WIDTH-1:0] count;
  logic             hold;
  logic             abort;
  logic             ready;
  logic             busy;
  logic [WIDTH-1:0] value;
  logic             tick;
  logic             done;
  logic             nCryOut;

  modport master (
    output start, count, hold, abort,
    input  ready, busy, value, tick, done, nCryOut
  );

  modport slave (
    input  start, count, hold, abort,
    output ready, busy, value, tick, done, nCryOut
  );
endinterface

// File: rtl/loop_counter.sv
// Loadable down-counter built from cascaded 4-bit slices with tick/done pulses.
// Optional feature: define LOOP_COUNTER_RELOAD_EN to auto-reload count at terminal.
module loop_counter #(
  parameter int WIDTH = 12
) (
  input  logic          clk,
  input  logic          nReset,
  loop_counter_if.slave bus
);

  localparam int SLICES = WIDTH / 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] w_value_nx;
  logic             r_tick;
  logic             w_tick_nx;
  logic             r_done;
  logic             w_done_nx;

  logic [WIDTH-1:0] w_dec;
  logic [SLICES:0]  w_borrow;
  logic             w_zero;

`ifdef LOOP_COUNTER_RELOAD_EN
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_reload_nx;
`endif

  // Borrow into slice g is the AND of all lower slices being zero, so the whole
  // decrement resolves in one cycle; the final borrow doubles as the zero flag.
  assign w_borrow[0] = 1'b1;
  for (genvar g = 0; g < SLICES; g++) begin : g_slice
    assign w_dec[4*g +: 4]  = r_value[4*g +: 4] - {3'b000, w_borrow[g]};
    assign w_borrow[g+1]    = w_borrow[g] & (r_value[4*g +: 4] == 4'h0);
  end
  assign w_zero = w_borrow[SLICES];

  always_comb begin
    w_state_nx = r_state;
    w_value_nx = r_value;
    w_tick_nx  = 1'b0;
    w_done_nx  = 1'b0;
`ifdef LOOP_COUNTER_RELOAD_EN
    w_reload_nx = r_reload;
`endif
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nx = RUN;
          w_value_nx = bus.count;
`ifdef LOOP_COUNTER_RELOAD_EN
          w_reload_nx = bus.count;
`endif
        end
      end
      RUN: begin
        if (bus.abort) begin
          w_state_nx = IDLE;
        end else if (!bus.hold) begin
          if (!w_zero) begin
            w_value_nx = w_dec;
            w_tick_nx  = 1'b1;
          end else begin
            w_done_nx = 1'b1;
`ifdef LOOP_COUNTER_RELOAD_EN
            w_value_nx = r_reload;
`else
            w_state_nx = IDLE;
`endif
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= IDLE;
      r_value <= '0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_value <= w_value_nx;
      r_tick  <= w_tick_nx;
      r_done  <= w_done_nx;
    end
  end

`ifdef LOOP_COUNTER_RELOAD_EN
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_reload <= '0;
    end else begin
      r_reload <= w_reload_nx;
    end
  end
`endif

  assign bus.ready   = (r_state == IDLE);
  assign bus.busy    = (r_state == RUN);
  assign bus.value   = r_value;
  assign bus.tick    = r_tick;
  assign bus.done    = r_done;
  assign bus.nCryOut = ~((r_state == RUN) & w_zero);

endmodule

// File: tb/tb_loop_counter.sv
// Directed plus randomized bench for loop_counter against a step-count reference model.
module tb_loop_counter;

  localparam int WIDTH = 12;

  logic clk;
  logic nReset;
  int   checks;
  int   errors;

  loop_counter_if #(.WIDTH(WIDTH)) bus ();

  loop_counter #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a run is "N loaded, k unheld edges elapsed"; value is N-k.
  bit               m_run;
  int               m_n;
  int               m_k;
  logic [WIDTH-1:0] m_val;
  bit               m_tick;
  bit               m_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("value",   64'(bus.value),   64'(m_val));
    chk("tick",    64'(bus.tick),    64'(m_tick));
    chk("done",    64'(bus.done),    64'(m_done));
    chk("ready",   64'(bus.ready),   64'(!m_run));
    chk("busy",    64'(bus.busy),    64'(m_run));
    chk("nCryOut", 64'(bus.nCryOut), 64'(!(m_run && m_val == 0)));
  endtask

  task automatic model_reset();
    m_run  = 0;
    m_n    = 0;
    m_k    = 0;
    m_val  = '0;
    m_tick = 0;
    m_done = 0;
  endtask

  task automatic cyc(input bit s, input int c, input bit h, input bit a);
    bus.start = s;
    bus.count = WIDTH'(c);
    bus.hold  = h;
    bus.abort = a;
    m_tick = 0;
    m_done = 0;
    if (!m_run) begin
      if (s) begin
        m_run = 1;
        m_n   = c;
        m_k   = 0;
        m_val = WIDTH'(c);
      end
    end else if (a) begin
      m_run = 0;
    end else if (!h) begin
      if (m_k < m_n) begin
        m_k++;
        m_val  = WIDTH'(m_n - m_k);
        m_tick = 1;
      end else begin
        m_done = 1;
`ifdef LOOP_COUNTER_RELOAD_EN
        m_k   = 0;
        m_val = WIDTH'(m_n);
`else
        m_run = 0;
`endif
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    nReset    = 1'b0;
    bus.start = 1'b0;
    bus.count = '0;
    bus.hold  = 1'b0;
    bus.abort = 1'b0;
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    #3;
    nReset = 1'b1;
    #3;

    // count = 3: 3,2,1,0 then done with ready
    cyc(1, 3, 0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // count = 0: one busy cycle with nCryOut low, then done
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    // start accepted in the done cycle
    cyc(1, 5, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    repeat (5) cyc(0, 0, 0, 0);

    // count = 0x100 across slice boundary, start ignored while busy, abort+hold
    cyc(1, 'h100, 0, 0);
    cyc(1, 'h007, 0, 0);
    cyc(1, 'h009, 0, 0);
    chk("value_0FE", 64'(bus.value), 64'h0FE);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 1);

    // count = 0xFFF, asynchronous reset mid-run
    cyc(1, 'hFFF, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    #3;
    nReset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    #2;
    nReset = 1'b1;
    repeat (3) cyc(0, 0, 0, 0);

    // count = 2: done every 3 cycles with reload, single done otherwise
    cyc(1, 2, 0, 0);
    repeat (9) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 3) == 0, int'($urandom_range(0, 9)),
          ($urandom % 5) == 0, ($urandom % 29) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/loop_counter.md
LOOP_COUNTER -- requirements
Module: loop_counter

Interface
REQ-001 Parameter WIDTH, 12, counter width in bits; SHALL be a multiple of 4 in the range 4..36 (cascaded 4-bit slices).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 nReset  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to load count and begin counting down.
REQ-005 count  input  WIDTH  initial count, sampled on the accepting edge.
REQ-006 ready  output  1  high while the block can accept start.
REQ-007 hold  input  1  freezes value for the cycle while RUN.
REQ-008 abort  input  1  terminates RUN without done.
REQ-009 busy  output  1  high while in RUN.
REQ-010 value  output  WIDTH  current count.
REQ-011 tick  output  1  registered; one-cycle pulse following each decrement edge.
REQ-012 done  output  1  registered; one-cycle pulse on terminal count.
REQ-013 nCryOut  output  1  combinational terminal borrow, active-low: low when busy and value == 0.

Function
REQ-014 States SHALL be IDLE and RUN only; ready = (state == IDLE); busy = (state == RUN).
REQ-015 Accept: start && ready at an edge -> next cycle state RUN, value = count.
REQ-016 start while busy SHALL be ignored; no queuing.
REQ-017 RUN, abort = 1: next state IDLE, value held, no done, no tick; abort has priority over hold and terminal count.
REQ-018 RUN, abort = 0, hold = 1: value, state and outputs held; tick = 0 next cycle.
REQ-019 RUN, abort = 0, hold = 0, value != 0: value <= value - 1; tick = 1 next cycle.
REQ-020 RUN, abort = 0, hold = 0, value == 0: terminal edge; done = 1 next cycle, tick = 0, value stays 0, state per REQ-027/REQ-028.
REQ-021 Load of N SHALL reach the terminal edge exactly N+1 unheld edges after the accepting edge. count = 0 gives done one unheld edge after accept.
REQ-022 Decrement SHALL be modulo 2^WIDTH arithmetic. The borrow SHALL propagate across all 4-bit slices within the same cycle, with no ripple-delay cycles.
REQ-023 done and tick SHALL never be high in the same cycle; each is high for at most one cycle per event.
REQ-024 In the cycle done = 1 (non-reload) the state is IDLE and ready = 1. A start in that cycle SHALL be accepted.
REQ-025 In IDLE, value SHALL retain its last value. abort and hold SHALL be ignored in IDLE.

Reset
REQ-026 nReset low SHALL immediately force state IDLE, value = 0, tick = 0, done = 0 (ready = 1, busy = 0, nCryOut = 1). This applies mid-RUN, and no done is produced. Release is taken synchronously on the next clk edge.

Configuration
REQ-027 With LOOP_COUNTER_RELOAD_EN defined: count is also captured into an internal reload register on accept. At each terminal edge, value <= reload register and state stays RUN, so done pulses every N+1 unheld edges. Only abort or reset exits RUN.
REQ-028 Without LOOP_COUNTER_RELOAD_EN: no reload register exists; the terminal edge returns state to IDLE.

Verification
REQ-029 WIDTH = 12, start with count = 3, hold = 0 -> value 3,2,1,0 on successive cycles; tick pulses three times; done single pulse on the 5th cycle after accept; ready = 1 with done.
REQ-030 count = 0 -> busy for one cycle, then done = 1, no tick; nCryOut low during that busy cycle.
REQ-031 count = 5, hold high for 2 cycles mid-count -> done delayed by exactly 2 cycles, value frozen while held.
REQ-032 count = 0x100, abort at value = 0x0FE, hold also high -> IDLE next cycle, value = 0x0FE, no done; start ignored while busy earlier.
REQ-033 count = 0xFFF, nReset pulsed low asynchronously mid-RUN -> outputs at reset values before the next edge; no done after release.
REQ-034 LOOP_COUNTER_RELOAD_EN defined, count = 2 -> done every 3 cycles, repeating until abort; without the macro -> single done, then IDLE.
